expand_sched: RTL and testbench
===============================

Name: expand_sched

Overview:
- Sequencer for the Blowfish/bcrypt key-expansion sweep.
- Runs the Feistel encryption core 521 times back-to-back, chaining each encryption's output into the next encryption's input.
- Writes each 64-bit result into the P-array (18 words), then into the four S-boxes (1024 words).
- Owns both SRAM ports: passes them through to the Feistel core while it runs, and drives them itself for result write-back.

Parameters:
- P_ARRAY_OFFSET, 4000: SRAM word address of P[0].
- NUM_P, 18: P-array words.
- NUM_S, 1024: S-box words. S[k] lives at SRAM address k.

Ports:
- clk  input  1  clock
- reset_l  input  1  asynchronous active-low reset
- go  input  1  start pulse; sampled in IDLE only
- busy  output  1  high from the cycle after go until done
- done  output  1  one-cycle completion pulse
- fe_start  output  1  start strobe to Feistel core
- fe_L, fe_R  output  32 each  plaintext halves to core
- fe_resultL, fe_resultR  input  32 each  core result
- fe_done  input  1  core completion pulse
- fe_addr_a, fe_addr_b  input  12 each  core SRAM addresses
- fe_cs_a_l, fe_we_a_l, fe_oe_a_l  input  1 each  core port-A strobes
- fe_cs_b_l, fe_we_b_l, fe_oe_b_l  input  1 each  core port-B strobes
- sram_addr_a, sram_addr_b  output  12 each  SRAM addresses
- sram_din_a, sram_din_b  output  32 each  SRAM write data
- sram_cs_a_l, sram_we_a_l, sram_oe_a_l  output  1 each  SRAM port-A strobes
- sram_cs_b_l, sram_we_b_l, sram_oe_b_l  output  1 each  SRAM port-B strobes
- salt  input  128  present only with EXPAND_SALT_EN; words salt[31:0]..salt[127:96]

Behaviour:
- Clock and reset: one clock (clk); reset_l is asynchronous, active-low.
- Reset values: state=IDLE; busy=0; done=0; fe_start=0; idx=0; chainL=chainR=0; all sram_*_l=1; sram_addr=0; sram_din=0.
- IDLE: go=1 -> LAUNCH, clear idx, chainL and chainR.
- LAUNCH: fe_start=1 for exactly one cycle; fe_L=chainL and fe_R=chainR are held stable from LAUNCH until fe_done. Next state RUN.
- RUN: the core owns the SRAM; every sram_* strobe/address equals the corresponding fe_* input combinationally, and sram_din=0. Stay in RUN until fe_done=1, then -> WRITE, latching fe_resultL/R into chainL/R.
- WRITE (1 cycle): the controller owns the SRAM.
  - Port A: cs=0, we=0, oe=1, addr=map(idx), din=chainL.
  - Port B: same strobes, addr=map(idx+1), din=chainR.
  - map(i) = P_ARRAY_OFFSET+i when i<NUM_P, else i-NUM_P.
  - Then idx+=2. If the new idx equals NUM_P+NUM_S (1042) -> FINISH, else -> LAUNCH.
- FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Outside RUN and WRITE, all sram chip-selects are 1.
- Totals: 521 encryptions and 521 write cycles. Latency = 521*(2+Tfe) + 1 cycles from go to done, where Tfe is the number of RUN cycles.
- idx is 11 bits. It never wraps; the terminal compare is exact.
- go while busy: ignored.
- fe_done outside RUN: ignored.
- fe_done in the same cycle as LAUNCH: ignored; the core must not complete in 0 cycles.
- Reset mid-operation: immediate return to IDLE with reset values. SRAM contents are left partially updated; a fresh go restarts from idx=0.

Optional Feature:
- Macro: EXPAND_SALT_EN.
- Defined: the salt port exists. In LAUNCH and RUN, fe_L = chainL ^ salt_word[s] and fe_R = chainR ^ salt_word[s+1]. s starts at 0 on go and toggles between 0 and 2 after each WRITE (EksBlowfish salted expansion).
- Undefined: no salt port; fe_L=chainL, fe_R=chainR.

Decomposition:
- Package expand_pkg holds:
  - the state enum (IDLE, LAUNCH, RUN, WRITE, FINISH);
  - constants NUM_P, NUM_S and P_ARRAY_OFFSET;
  - the address-map function map().
- One sub-module, sram_port_mux: combinational owner select between the core and the controller for one SRAM port, instantiated twice (ports A and B).

Test Plan:
- Stub core returns L+1 / R+2 after 3 cycles; pulse go. First WRITE: A@4000=1, B@4001=2. Second WRITE: A@4002=2, B@4003=4.
- Same run, continue to completion. The 10th WRITE targets A@0 / B@1 (first S-box write). The last WRITE targets A@1022 / B@1023. done pulses exactly once after 521 writes; busy falls with done.
- During RUN, drive distinct fe_addr/strobe patterns -> sram_* match them cycle-for-cycle. Outside RUN/WRITE, all sram_cs_*_l = 1.
- go re-pulsed at encryption 5 -> no restart; write count and addresses are unchanged.
- Assert reset_l low mid-RUN at encryption 100 -> outputs reach reset values asynchronously, with no further writes. A new go restarts with the first WRITE at 4000.
- With EXPAND_SALT_EN, salt = {4,3,2,1}: first fe_L=1, fe_R=2. After the first write, fe_L = resultL^3 and fe_R = resultR^4.

Source files
------------

// File: rtl/expand_sched_pkg.sv
// Shared types, constants and address map for the key-expansion sequencer.
package expand_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StWrite,
    StFinish
  } state_e;

  localparam int unsigned NUM_P          = 18;
  localparam int unsigned NUM_S          = 1024;
  localparam int unsigned P_ARRAY_OFFSET = 4000;

  localparam int unsigned IDX_W  = 11;
  localparam int unsigned ADDR_W = 12;

  // Terminal index after the last write pair.
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_P + NUM_S);

  // Word index into P/S space -> SRAM word address.
  function automatic logic [ADDR_W-1:0] map(input logic [IDX_W-1:0] i);
    if (i < IDX_W'(NUM_P)) begin
      return ADDR_W'(P_ARRAY_OFFSET) + ADDR_W'(i);
    end else begin
      return ADDR_W'(i - IDX_W'(NUM_P));
    end
  endfunction

endpackage

// File: rtl/expand_sched_sram_port_mux.sv
// One SRAM port: selects between the Feistel core and the write-back controller.
module sram_port_mux
  import expand_pkg::*;
(
  input  logic              core_own,
  input  logic              ctl_own,
  input  logic [ADDR_W-1:0] fe_addr,
  input  logic              fe_cs_l,
  input  logic              fe_we_l,
  input  logic              fe_oe_l,
  input  logic [ADDR_W-1:0] ctl_addr,
  input  logic [31:0]       ctl_din,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  output logic              sram_cs_l,
  output logic              sram_we_l,
  output logic              sram_oe_l
);

  // Core passes straight through; controller issues a write; otherwise port is deselected.
  always_comb begin
    sram_addr = '0;
    sram_din  = '0;
    sram_cs_l = 1'b1;
    sram_we_l = 1'b1;
    sram_oe_l = 1'b1;
    if (core_own) begin
      sram_addr = fe_addr;
      sram_cs_l = fe_cs_l;
      sram_we_l = fe_we_l;
      sram_oe_l = fe_oe_l;
    end else if (ctl_own) begin
      sram_addr = ctl_addr;
      sram_din  = ctl_din;
      sram_cs_l = 1'b0;
      sram_we_l = 1'b0;
    end
  end

endmodule

// File: rtl/expand_sched.sv
// Blowfish/bcrypt key-expansion sequencer: 521 chained encryptions written into P then S.
// Optional salted (EksBlowfish) expansion is enabled by defining EXPAND_SALT_EN.
module expand_sched
  import expand_pkg::*;
(
  input  logic              clk,
  input  logic              reset_l,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              fe_start,
  output logic [31:0]       fe_L,
  output logic [31:0]       fe_R,
  input  logic [31:0]       fe_resultL,
  input  logic [31:0]       fe_resultR,
  input  logic              fe_done,
  input  logic [ADDR_W-1:0] fe_addr_a,
  input  logic [ADDR_W-1:0] fe_addr_b,
  input  logic              fe_cs_a_l,
  input  logic              fe_we_a_l,
  input  logic              fe_oe_a_l,
  input  logic              fe_cs_b_l,
  input  logic              fe_we_b_l,
  input  logic              fe_oe_b_l,
`ifdef EXPAND_SALT_EN
  input  logic [127:0]      salt,
`endif
  output logic [ADDR_W-1:0] sram_addr_a,
  output logic [ADDR_W-1:0] sram_addr_b,
  output logic [31:0]       sram_din_a,
  output logic [31:0]       sram_din_b,
  output logic              sram_cs_a_l,
  output logic              sram_we_a_l,
  output logic              sram_oe_a_l,
  output logic              sram_cs_b_l,
  output logic              sram_we_b_l,
  output logic              sram_oe_b_l
);

  state_e           state_q;
  logic             busy_q, done_q, fe_start_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      chain_l_q, chain_r_q;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] idx_odd;

  assign idx_next = idx_q + IDX_W'(2);
  assign idx_odd  = idx_q + IDX_W'(1);

`ifdef EXPAND_SALT_EN
  // Selects salt words {0,1} when low, {2,3} when high.
  logic salt_sel_q;

  // Salt word pair alternates after every write-back.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      salt_sel_q <= 1'b0;
    end else if (state_q == StIdle && go) begin
      salt_sel_q <= 1'b0;
    end else if (state_q == StWrite) begin
      salt_sel_q <= ~salt_sel_q;
    end
  end

  assign fe_L = chain_l_q ^ (salt_sel_q ? salt[95:64]  : salt[31:0]);
  assign fe_R = chain_r_q ^ (salt_sel_q ? salt[127:96] : salt[63:32]);
`else
  assign fe_L = chain_l_q;
  assign fe_R = chain_r_q;
`endif

  // Sequencer FSM with registered status/strobe outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fe_start_q <= 1'b0;
      idx_q      <= '0;
      chain_l_q  <= '0;
      chain_r_q  <= '0;
    end else begin
      fe_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            state_q    <= StLaunch;
            busy_q     <= 1'b1;
            fe_start_q <= 1'b1;
            idx_q      <= '0;
            chain_l_q  <= '0;
            chain_r_q  <= '0;
          end
        end
        StLaunch: state_q <= StRun;
        StRun: begin
          if (fe_done) begin
            chain_l_q <= fe_resultL;
            chain_r_q <= fe_resultR;
            state_q   <= StWrite;
          end
        end
        StWrite: begin
          idx_q <= idx_next;
          if (idx_next == IDX_LAST) begin
            state_q <= StFinish;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= StLaunch;
            fe_start_q <= 1'b1;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign fe_start = fe_start_q;

  logic core_own, ctl_own;
  assign core_own = (state_q == StRun);
  assign ctl_own  = (state_q == StWrite);

  sram_port_mux u_mux_a (
    .core_own  (core_own),
    .ctl_own   (ctl_own),
    .fe_addr   (fe_addr_a),
    .fe_cs_l   (fe_cs_a_l),
    .fe_we_l   (fe_we_a_l),
    .fe_oe_l   (fe_oe_a_l),
    .ctl_addr  (map(idx_q)),
    .ctl_din   (chain_l_q),
    .sram_addr (sram_addr_a),
    .sram_din  (sram_din_a),
    .sram_cs_l (sram_cs_a_l),
    .sram_we_l (sram_we_a_l),
    .sram_oe_l (sram_oe_a_l)
  );

  sram_port_mux u_mux_b (
    .core_own  (core_own),
    .ctl_own   (ctl_own),
    .fe_addr   (fe_addr_b),
    .fe_cs_l   (fe_cs_b_l),
    .fe_we_l   (fe_we_b_l),
    .fe_oe_l   (fe_oe_b_l),
    .ctl_addr  (map(idx_odd)),
    .ctl_din   (chain_r_q),
    .sram_addr (sram_addr_b),
    .sram_din  (sram_din_b),
    .sram_cs_l (sram_cs_b_l),
    .sram_we_l (sram_we_b_l),
    .sram_oe_l (sram_oe_b_l)
  );

endmodule

// File: tb/tb_expand_sched.sv
// Directed bench for expand_sched with a 3-cycle stub Feistel core (result = L+1 / R+2).
module tb_expand_sched;

  logic        clk = 1'b0;
  logic        reset_l, go;
  logic        busy, done, fe_start, fe_done;
  logic [31:0] fe_L, fe_R, fe_resultL, fe_resultR;
  logic [11:0] fe_addr_a, fe_addr_b, sram_addr_a, sram_addr_b;
  logic        fe_cs_a_l, fe_we_a_l, fe_oe_a_l, fe_cs_b_l, fe_we_b_l, fe_oe_b_l;
  logic [31:0] sram_din_a, sram_din_b;
  logic        sram_cs_a_l, sram_we_a_l, sram_oe_a_l, sram_cs_b_l, sram_we_b_l, sram_oe_b_l;
`ifdef EXPAND_SALT_EN
  logic [127:0] salt = {32'd4, 32'd3, 32'd2, 32'd1};
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  expand_sched dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .go          (go),
    .busy        (busy),
    .done        (done),
    .fe_start    (fe_start),
    .fe_L        (fe_L),
    .fe_R        (fe_R),
    .fe_resultL  (fe_resultL),
    .fe_resultR  (fe_resultR),
    .fe_done     (fe_done),
    .fe_addr_a   (fe_addr_a),
    .fe_addr_b   (fe_addr_b),
    .fe_cs_a_l   (fe_cs_a_l),
    .fe_we_a_l   (fe_we_a_l),
    .fe_oe_a_l   (fe_oe_a_l),
    .fe_cs_b_l   (fe_cs_b_l),
    .fe_we_b_l   (fe_we_b_l),
    .fe_oe_b_l   (fe_oe_b_l),
`ifdef EXPAND_SALT_EN
    .salt        (salt),
`endif
    .sram_addr_a (sram_addr_a),
    .sram_addr_b (sram_addr_b),
    .sram_din_a  (sram_din_a),
    .sram_din_b  (sram_din_b),
    .sram_cs_a_l (sram_cs_a_l),
    .sram_we_a_l (sram_we_a_l),
    .sram_oe_a_l (sram_oe_a_l),
    .sram_cs_b_l (sram_cs_b_l),
    .sram_we_b_l (sram_we_b_l),
    .sram_oe_b_l (sram_oe_b_l)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] salt_word(input int k);
`ifdef EXPAND_SALT_EN
    logic [127:0] s;
    s = salt;
    return s[32*k +: 32];
`else
    return (k < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  function automatic int exp_map(input int i);
    return (i < 18) ? 4000 + i : i - 18;
  endfunction

  // Stub core: accepts fe_start, raises fe_done on the 3rd RUN cycle.
  logic [1:0]  cnt;
  logic [31:0] res_l, res_r;
  logic        wr_pending;
  logic [7:0]  tcnt = 8'd0;

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt        <= 2'd0;
      res_l      <= 32'd0;
      res_r      <= 32'd0;
      wr_pending <= 1'b0;
    end else begin
      wr_pending <= fe_done;
      if (fe_start) begin
        cnt   <= 2'd3;
        res_l <= fe_L + 32'd1;
        res_r <= fe_R + 32'd2;
      end else if (cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  always @(posedge clk) tcnt <= tcnt + 8'd1;

  assign fe_done    = (cnt == 2'd1);
  assign fe_resultL = res_l;
  assign fe_resultR = res_r;
  assign fe_addr_a  = {tcnt[5:0], 6'h2a};
  assign fe_addr_b  = ~{tcnt[6:1], 6'h15};
  assign fe_cs_a_l  = tcnt[0];
  assign fe_cs_b_l  = ~tcnt[0];
  assign fe_we_a_l  = 1'b1;
  assign fe_we_b_l  = 1'b1;
  assign fe_oe_a_l  = tcnt[1];
  assign fe_oe_b_l  = tcnt[2];

  // Reference model and bus monitor, sampled on the falling edge.
  logic [31:0] m_l, m_r, nl, nr;
  int          m_s;
  int          wr_n = 0;
  int          done_n = 0;

  always @(negedge clk) begin
    if (!reset_l) begin
      m_l = 32'd0;
      m_r = 32'd0;
      m_s = 0;
    end else begin
      if (go && !busy) begin
        m_l = 32'd0; m_r = 32'd0; m_s = 0; wr_n = 0; done_n = 0;
      end
      if (done) done_n++;
      if (fe_start) begin
        check("launch_fe_L", fe_L, m_l ^ salt_word(m_s));
        check("launch_fe_R", fe_R, m_r ^ salt_word(m_s + 1));
        if (wr_n == 0) begin
          check("first_fe_L", fe_L, salt_word(0));
          check("first_fe_R", fe_R, salt_word(1));
        end
      end
      if (cnt != 2'd0) begin
        if (wr_n < 4) begin
          check("run_port_a", {sram_addr_a, sram_cs_a_l, sram_we_a_l, sram_oe_a_l},
                {fe_addr_a, fe_cs_a_l, fe_we_a_l, fe_oe_a_l});
          check("run_port_b", {sram_addr_b, sram_cs_b_l, sram_we_b_l, sram_oe_b_l},
                {fe_addr_b, fe_cs_b_l, fe_we_b_l, fe_oe_b_l});
          check("run_din", {sram_din_a, sram_din_b}, 64'd0);
        end
      end else if (wr_pending) begin
        nl = (m_l ^ salt_word(m_s)) + 32'd1;
        nr = (m_r ^ salt_word(m_s + 1)) + 32'd2;
        check("wr_strobe_a", {sram_cs_a_l, sram_we_a_l, sram_oe_a_l}, 3'b001);
        check("wr_strobe_b", {sram_cs_b_l, sram_we_b_l, sram_oe_b_l}, 3'b001);
        check("wr_addr_a", sram_addr_a, exp_map(2 * wr_n));
        check("wr_addr_b", sram_addr_b, exp_map(2 * wr_n + 1));
        check("wr_din_a", sram_din_a, nl);
        check("wr_din_b", sram_din_b, nr);
        check("wr_in_range", (wr_n < 521), 1);
        if (wr_n == 0) check("wr0_addr", {sram_addr_a, sram_addr_b}, {12'd4000, 12'd4001});
        if (wr_n == 9) check("wr9_addr", {sram_addr_a, sram_addr_b}, {12'd0, 12'd1});
        if (wr_n == 520) check("wr520_addr", {sram_addr_a, sram_addr_b}, {12'd1022, 12'd1023});
`ifndef EXPAND_SALT_EN
        if (wr_n == 0) check("wr0_data", {sram_din_a, sram_din_b}, {32'd1, 32'd2});
        if (wr_n == 1) check("wr1_data", {sram_din_a, sram_din_b}, {32'd2, 32'd4});
`else
        if (wr_n == 1) check("wr1_salt", {fe_L, fe_R}, {res_l ^ 32'd3, res_r ^ 32'd4});
`endif
        m_l = nl; m_r = nr; m_s = (m_s == 0) ? 2 : 0;
        wr_n++;
      end else begin
        check("idle_cs", {sram_cs_a_l, sram_cs_b_l}, 2'b11);
      end
    end
  end

  task automatic check_reset_values();
    check("rst_ctl", {busy, done, fe_start}, 3'b000);
    check("rst_strobes", {sram_cs_a_l, sram_we_a_l, sram_oe_a_l,
                          sram_cs_b_l, sram_we_b_l, sram_oe_b_l}, 6'h3f);
    check("rst_addr", {sram_addr_a, sram_addr_b}, 24'd0);
    check("rst_din", {sram_din_a, sram_din_b}, 64'd0);
    check("rst_fe", {fe_L, fe_R}, {salt_word(0), salt_word(1)});
  endtask

  // Pulses go, waits for done within a cycle budget and checks the latency.
  task automatic run_to_done(input bit repulse);
    int  cycles;
    bit  gone;
    gone = 1'b0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check("go_busy_start", {busy, fe_start}, 2'b11);
    @(posedge clk); #1;
    check("start_one_cycle", fe_start, 1'b0);
    cycles = 2;
    while (!done && cycles < 3000) begin
      go = repulse && (wr_n == 5) && !gone;
      if (go) gone = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    go = 1'b0;
    check("done_seen", done, 1'b1);
    check("latency", cycles, 521 * 5 + 1);
    check("busy_falls_with_done", busy, 1'b0);
    check("write_total", wr_n, 521);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulse_count", done_n, 1);
  endtask

  initial begin
    int  n;
    reset_l = 1'b0;
    go      = 1'b0;
    #12;
    check_reset_values();
    @(posedge clk); #1;
    reset_l = 1'b1;
    @(posedge clk); #1;
    check_reset_values();

    run_to_done(1'b1);

    // Second run: reset asynchronously in the middle of encryption 100.
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 0;
    while (!(wr_n == 100 && cnt == 2'd2) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_enc100", (wr_n == 100 && cnt == 2'd2), 1'b1);
    #1;
    reset_l = 1'b0;
    #1;
    check_reset_values();
    check("rst_wr_count", wr_n, 100);
    repeat (3) @(posedge clk);
    #1;
    reset_l = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_writes_after_reset", wr_n, 100);
    check_reset_values();

    run_to_done(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
